boa_mmio_copier: RTL

Word-granular bus initiator that copies a block of 32-bit words from a source address range to a destination address range over `boa_mem_bus`. It is the requester-side counterpart of the MMIO responders (readable/writable registers, RAM), and sits in the SoC as an extra initiator ahead of the bus arbiter. The block offloads simple block moves, for example snapshotting MMIO status words into RAM.

---
 rtl/boa_copier_pkg.sv | 24 ++
 rtl/boa_mem_bus.sv | 17 +
 rtl/boa_mmio_copier.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/boa_copier_pkg.sv
// Shared types and constants for the boa_mmio_copier block-move initiator.
package boa_copier_pkg;

   localparam int unsigned BOA_ALEN = 32;
   localparam int unsigned BOA_AW   = BOA_ALEN - 2;
   localparam int unsigned BOA_DW   = 32;
   localparam int unsigned BOA_BEW  = 4;

   localparam logic [BOA_BEW-1:0] BOA_COPIER_WE_ALL = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_CAPT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // Word address increment, wrapping modulo 2^(alen-2).
   function automatic logic [BOA_AW-1:0] word_inc(input logic [BOA_AW-1:0] a);
      return a + BOA_AW'(1);
   endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Word-granular peripheral bus shared by the CPU-side initiators and MMIO responders.
interface boa_mem_bus;
   import boa_copier_pkg::*;

   logic                    re;
   logic [BOA_BEW-1:0]      we;
   logic [BOA_ALEN-1:2]     addr;
   logic [BOA_DW-1:0]       wdata;
   logic [BOA_DW-1:0]       rdata;
   logic                    ready;

   modport CPU (output re, output we, output addr, output wdata,
                input  rdata, input ready);
   modport MEM (input  re, input we, input addr, input wdata,
                output rdata, output ready);

endinterface

// File: rtl/boa_mmio_copier.sv
// Bus initiator copying len words from src to dst, one read/write pair per word.
// Define BOA_COPIER_FILL_EN to add the fill ports (write a constant pattern, no reads).
module boa_mmio_copier
   import boa_copier_pkg::*;
#(
   parameter int unsigned lw = 16
) (
   input  logic              clk,
   input  logic              rst,
   boa_mem_bus.CPU           bus,
   input  logic              start,
   input  logic [BOA_AW-1:0] src,
   input  logic [BOA_AW-1:0] dst,
   input  logic [lw-1:0]     len,
`ifdef BOA_COPIER_FILL_EN
   input  logic              fill,
   input  logic [BOA_DW-1:0] pattern,
`endif
   output logic              busy,
   output logic              done
);

   state_t              r_state, w_state;
   logic [BOA_AW-1:0]   r_sp, w_sp;
   logic [BOA_AW-1:0]   r_dp, w_dp;
   logic [lw-1:0]       r_cnt, w_cnt;
   logic                r_re, w_re;
   logic [BOA_BEW-1:0]  r_we, w_we;
   logic [BOA_AW-1:0]   r_addr, w_addr;
   logic [BOA_DW-1:0]   r_wdata, w_wdata;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
`ifdef BOA_COPIER_FILL_EN
   logic                r_fill, w_fill;
`endif

   // Next-state and next-output logic; r_wdata doubles as the capture buffer.
   always_comb begin
      w_state = r_state;
      w_sp    = r_sp;
      w_dp    = r_dp;
      w_cnt   = r_cnt;
      w_re    = r_re;
      w_we    = r_we;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_busy  = r_busy;
      w_done  = 1'b0;
`ifdef BOA_COPIER_FILL_EN
      w_fill  = r_fill;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_sp  = src;
               w_dp  = dst;
               w_cnt = len;
`ifdef BOA_COPIER_FILL_EN
               w_fill = fill;
`endif
               if (len == '0) begin
                  w_state = ST_FIN;
                  w_done  = 1'b1;
               end
`ifdef BOA_COPIER_FILL_EN
               else if (fill) begin
                  w_state = ST_WRITE;
                  w_we    = BOA_COPIER_WE_ALL;
                  w_addr  = dst;
                  w_wdata = pattern;
                  w_busy  = 1'b1;
               end
`endif
               else begin
                  w_state = ST_READ;
                  w_re    = 1'b1;
                  w_addr  = src;
                  w_busy  = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (bus.ready) begin
               w_state = ST_CAPT;
               w_re    = 1'b0;
            end
         end
         ST_CAPT: begin
            w_state = ST_WRITE;
            w_wdata = bus.rdata;
            w_we    = BOA_COPIER_WE_ALL;
            w_addr  = r_dp;
         end
         ST_WRITE: begin
            if (bus.ready) begin
               w_sp  = word_inc(r_sp);
               w_dp  = word_inc(r_dp);
               w_cnt = r_cnt - lw'(1);
               w_we  = '0;
               if (r_cnt == lw'(1)) begin
                  w_state = ST_FIN;
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
               end
`ifdef BOA_COPIER_FILL_EN
               else if (r_fill) begin
                  // Pattern is still held in r_wdata; only the address advances.
                  w_we   = BOA_COPIER_WE_ALL;
                  w_addr = word_inc(r_dp);
               end
`endif
               else begin
                  w_state = ST_READ;
                  w_re    = 1'b1;
                  w_addr  = word_inc(r_sp);
               end
            end
         end
         ST_FIN: begin
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_sp    <= '0;
         r_dp    <= '0;
         r_cnt   <= '0;
         r_re    <= 1'b0;
         r_we    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef BOA_COPIER_FILL_EN
         r_fill  <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_sp    <= w_sp;
         r_dp    <= w_dp;
         r_cnt   <= w_cnt;
         r_re    <= w_re;
         r_we    <= w_we;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_busy  <= w_busy;
         r_done  <= w_done;
`ifdef BOA_COPIER_FILL_EN
         r_fill  <= w_fill;
`endif
      end
   end

   assign bus.re    = r_re;
   assign bus.we    = r_we;
   assign bus.addr  = r_addr;
   assign bus.wdata = r_wdata;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
